// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: sequences INIT/clear and arbitrates decode reads and writeback
// writes onto the single register file command slot. REG_FILE_CTRL_FAIR_EN enables read fairness.
module reg_file_ctrl #(
  parameter int WORD_SIZE     = 32,
  parameter int REG_FILE_SIZE = 5,
  parameter int MAX_WR_STREAK = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [REG_FILE_SIZE-1:0] rd_num1,
  input  logic [REG_FILE_SIZE-1:0] rd_num2,
  output logic                     rd_resp_valid,
  output logic [WORD_SIZE-1:0]     rd_data1,
  output logic [WORD_SIZE-1:0]     rd_data2,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [REG_FILE_SIZE-1:0] wr_num,
  input  logic [WORD_SIZE-1:0]     wr_val,
  input  logic                     clr_req,
  output logic                     clr_done,
  output logic                     busy,
  output logic [REG_FILE_SIZE-1:0] rf_get_num1,
  output logic [REG_FILE_SIZE-1:0] rf_get_num2,
  output logic [REG_FILE_SIZE-1:0] rf_set_num,
  output logic [WORD_SIZE-1:0]     rf_set_val,
  output logic                     rf_get_enable,
  output logic                     rf_set_enable,
  output logic                     rf_reset_enable,
  input  logic [WORD_SIZE-1:0]     rf_out1,
  input  logic [WORD_SIZE-1:0]     rf_out2
);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  if (MAX_WR_STREAK < 1 || MAX_WR_STREAK > 15) begin : g_bad_streak
    $error("reg_file_ctrl: MAX_WR_STREAK must be within 1..15");
  end

  logic [1:0] state;
  logic       idle_open;
  logic       force_rd;
  logic       wr_grant;
  logic       rd_grant;

  assign idle_open = (state == IDLE) && !clr_req;
  assign wr_ready  = idle_open && !force_rd;
  assign rd_ready  = idle_open && (!wr_valid || force_rd);
  assign wr_grant  = wr_valid && wr_ready;
  assign rd_grant  = rd_valid && rd_ready;
  assign busy      = (state != IDLE) || clr_req;

  assign rd_data1  = rf_out1;
  assign rd_data2  = rf_out2;

`ifdef REG_FILE_CTRL_FAIR_EN
  // Counts writes granted over a waiting read; at the limit the read is forced through.
  logic [3:0] wr_streak;

  assign force_rd = (wr_streak == 4'(MAX_WR_STREAK));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_streak <= '0;
    end else if (rd_grant || !rd_valid) begin
      wr_streak <= '0;
    end else if (wr_grant) begin
      wr_streak <= wr_streak + 4'd1;
    end
  end
`else
  assign force_rd = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= INIT;
      rf_get_enable   <= 1'b0;
      rf_set_enable   <= 1'b0;
      rf_reset_enable <= 1'b0;
      rf_get_num1     <= '0;
      rf_get_num2     <= '0;
      rf_set_num      <= '0;
      rf_set_val      <= '0;
      rd_resp_valid   <= 1'b0;
      clr_done        <= 1'b0;
    end else begin
      rf_get_enable   <= rd_grant;
      rf_set_enable   <= wr_grant;
      rf_reset_enable <= 1'b0;
      clr_done        <= 1'b0;
      // The file latches read data one edge after the get command.
      rd_resp_valid   <= rf_get_enable;
      if (wr_grant) begin
        rf_set_num <= wr_num;
        rf_set_val <= wr_val;
      end
      if (rd_grant) begin
        rf_get_num1 <= rd_num1;
        rf_get_num2 <= rd_num2;
      end
      case (state)
        INIT: begin
          // First edge issues the clear, second edge (clear done) opens IDLE.
          if (!rf_reset_enable) begin
            rf_reset_enable <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state           <= CLEAR;
            rf_reset_enable <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= IDLE;
          clr_done <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl: behavioural register file environment,
// architectural reference model and a response scoreboard.
module tb_reg_file_ctrl;
  localparam int W  = 32;
  localparam int N  = 5;
  localparam int MW = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd_valid = 1'b0, rd_ready;
  logic [N-1:0] rd_num1 = '0, rd_num2 = '0;
  logic         rd_resp_valid;
  logic [W-1:0] rd_data1, rd_data2;
  logic         wr_valid = 1'b0, wr_ready;
  logic [N-1:0] wr_num = '0;
  logic [W-1:0] wr_val = '0;
  logic         clr_req = 1'b0, clr_done, busy;
  logic [N-1:0] rf_get_num1, rf_get_num2, rf_set_num;
  logic [W-1:0] rf_set_val;
  logic         rf_get_enable, rf_set_enable, rf_reset_enable;
  logic [W-1:0] rf_out1 = '0, rf_out2 = '0;

  reg_file_ctrl #(.WORD_SIZE(W), .REG_FILE_SIZE(N), .MAX_WR_STREAK(MW)) dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_num1(rd_num1), .rd_num2(rd_num2),
    .rd_resp_valid(rd_resp_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_num(wr_num), .wr_val(wr_val),
    .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
    .rf_get_num1(rf_get_num1), .rf_get_num2(rf_get_num2), .rf_set_num(rf_set_num),
    .rf_set_val(rf_set_val), .rf_get_enable(rf_get_enable), .rf_set_enable(rf_set_enable),
    .rf_reset_enable(rf_reset_enable), .rf_out1(rf_out1), .rf_out2(rf_out2)
  );

  always #5 clk = ~clk;

  // Register file environment; starts with garbage so the INIT clear matters.
  logic [W-1:0] rf_mem [32];
  initial foreach (rf_mem[i]) rf_mem[i] = $urandom;
  always @(posedge clk) begin
    if (rf_reset_enable) begin
      foreach (rf_mem[i]) rf_mem[i] <= '0;
    end else if (rf_set_enable) begin
      rf_mem[rf_set_num] <= rf_set_val;
    end
    if (rf_get_enable) begin
      rf_out1 <= rf_mem[rf_get_num1];
      rf_out2 <= rf_mem[rf_get_num2];
    end
  end

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int resp_cnt = 0;
  int resp_cyc[$];
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model [32];

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset)
      check("one_rf_cmd", 64'(32'(rf_get_enable) + 32'(rf_set_enable) + 32'(rf_reset_enable) <= 1), 64'd1);
    if (rd_resp_valid) begin
      resp_cnt++;
      resp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL rd_resp_unexpected: got pulse with data %0h/%0h expected none", rd_data1, rd_data2);
      end else begin
        check("rd_data", {rd_data1, rd_data2}, exp_q.pop_front());
      end
    end
  end

  task automatic zero_model();
    foreach (model[i]) model[i] = '0;
  endtask

  // Drive one cycle of requests and account for whatever the next edge grants.
  task automatic step(input logic wv, input logic [N-1:0] wn, input logic [W-1:0] wd,
                      input logic rv, input logic [N-1:0] n1, input logic [N-1:0] n2,
                      output logic wg, output logic rg);
    @(negedge clk);
    wr_valid = wv; wr_num = wn; wr_val = wd;
    rd_valid = rv; rd_num1 = n1; rd_num2 = n2;
    #1;
    wg = wv && wr_ready;
    rg = rv && rd_ready;
    if (wg && rg) check("dual_grant", 64'd1, 64'd0);
    if (wg) model[wn] = wd;
    if (rg) exp_q.push_back({model[n1], model[n2]});
  endtask

  task automatic idle_step();
    logic wg, rg;
    step(1'b0, '0, '0, 1'b0, '0, '0, wg, rg);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #2;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_seq(input string tag);
    @(negedge clk);
    reset = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; clr_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check({tag, "_rst_rfcmd"}, {61'd0, rf_get_enable, rf_set_enable, rf_reset_enable}, 64'd0);
    check({tag, "_rst_nums"}, {rf_get_num1, rf_get_num2, rf_set_num, rf_set_val}, 64'd0);
    check({tag, "_rst_pulses"}, {62'd0, rd_resp_valid, clr_done}, 64'd0);
    check({tag, "_rst_busy_rdy"}, {61'd0, busy, rd_ready, wr_ready}, 64'b100);
    reset = 1'b0;
    @(negedge clk);
    check({tag, "_init_clear"}, {61'd0, rf_reset_enable, busy, rd_ready}, 64'b110);
    check({tag, "_init_wr_rdy"}, 64'(wr_ready), 64'd0);
    @(negedge clk);
    check({tag, "_init_done"}, {60'd0, rf_reset_enable, busy, rd_ready, wr_ready}, 64'b0011);
    zero_model();
  endtask

  initial begin
    logic wg, rg, wdone;
    int base, cnt0, nres;

    reset_seq("boot");

    // RAW: same-cycle write and read, write first
    step(1'b1, 5'd3, 32'h1234, 1'b1, 5'd3, 5'd0, wg, rg);
    check("raw_wr_first", {62'd0, wg, rg}, 64'b10);
    step(1'b0, '0, '0, 1'b1, 5'd3, 5'd0, wg, rg);
    check("raw_rd_next", 64'(rg), 64'd1);
    check("raw_model", {model[3], model[0]}, {32'h1234, 32'h0});
    idle_step();
    drain();

    // Back-to-back reads of preloaded r1..r4
    for (int i = 1; i <= 4; i++) step(1'b1, N'(i), W'(i * 10), 1'b0, '0, '0, wg, rg);
    base = resp_cyc.size();
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, '0, 1'b1, N'(i), 5'd0, wg, rg);
      check("b2b_rd_grant", 64'(rg), 64'd1);
    end
    idle_step();
    drain();
    check("b2b_resp_count", 64'(resp_cyc.size() - base), 64'd4);
    if (resp_cyc.size() - base == 4)
      for (int i = 1; i < 4; i++)
        check("b2b_consecutive", 64'(resp_cyc[base + i] - resp_cyc[base + i - 1]), 64'd1);

    // Clear beats a pending write; the write then lands after the clear
    @(negedge clk);
    clr_req = 1'b1; wr_valid = 1'b1; wr_num = 5'd5; wr_val = 32'd7; rd_valid = 1'b0;
    #1;
    check("clr_blocks_rdy", {62'd0, wr_ready, rd_ready}, 64'd0);
    check("clr_busy", 64'(busy), 64'd1);
    wdone = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("clr_issue", {61'd0, rf_reset_enable, rf_set_enable, clr_done}, 64'b100);
        clr_req = 1'b0;
        zero_model();
      end
      if (k == 1) check("clr_done_pulse", {62'd0, clr_done, rf_reset_enable}, 64'b10);
      if (k == 2) check("clr_done_once", 64'(clr_done), 64'd0);
      if (wdone) wr_valid = 1'b0;
      #1;
      if (wr_valid && wr_ready && !wdone) begin
        wdone = 1'b1;
        model[5] = 32'd7;
      end
    end
    check("clr_write_landed", 64'(wdone), 64'd1);
    for (int i = 0; i < 16; i++) step(1'b0, '0, '0, 1'b1, N'(2 * i), N'(2 * i + 1), wg, rg);
    idle_step();
    drain();

    // Write/read contention held for 12 cycles
    idle_step();
    for (int i = 0; i < 12; i++) begin
      logic exp_w;
`ifdef REG_FILE_CTRL_FAIR_EN
      exp_w = (i % (MW + 1)) != MW;
`else
      exp_w = 1'b1;
`endif
      step(1'b1, N'($urandom_range(0, 31)), $urandom, 1'b1, N'($urandom_range(0, 31)),
           N'($urandom_range(0, 31)), wg, rg);
      check("contention_pattern", {62'd0, wg, rg}, {62'd0, exp_w, !exp_w});
    end
    idle_step();
    drain();

    // Randomized traffic
    for (int i = 0; i < 250; i++)
      step(1'($urandom_range(0, 99) < 55), N'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 99) < 60), N'($urandom_range(0, 31)), N'($urandom_range(0, 31)), wg, rg);
    idle_step();
    drain();

    // Reset the cycle after a read issues: response dropped, INIT reruns
    step(1'b0, '0, '0, 1'b1, 5'd1, 5'd2, wg, rg);
    check("midrst_rd_grant", 64'(rg), 64'd1);
    @(negedge clk);
    reset = 1'b1; rd_valid = 1'b0;
    exp_q.delete();
    cnt0 = resp_cnt;
    repeat (3) @(negedge clk);
    nres = resp_cnt - cnt0;
    check("midrst_no_resp", 64'(nres), 64'd0);
    reset_seq("rerun");
    step(1'b1, 5'd9, 32'hcafe, 1'b0, '0, '0, wg, rg);
    step(1'b0, '0, '0, 1'b1, 5'd9, 5'd1, wg, rg);
    check("post_rst_rd", 64'(rg), 64'd1);
    idle_step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
